spi_word_bridge: RTL and testbench

SPI slave front-end that sits between the STM32 SPI master and the matrix Controller. It deserializes MOSI into WORD_SIZE-bit words and presents each one on the rx side (Controller input bus, rising-edge-detected valid). It serializes result words offered by the Controller on the tx side onto MISO, and acknowledges each transmitted word with a stretched ready pulse.

---
 rtl/spi_word_bridge_if.sv | 26 ++
 rtl/spi_word_bridge.sv | 167 ++++++++++++++++
 tb/tb_spi_word_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_word_bridge_if.sv
// Bundles the SPI pins and the Controller-side rx/tx handshake of the SPI word bridge.
interface spi_word_bridge_if #(
   parameter int WORD_SIZE = 16
);
   logic                 sclk;
   logic                 cs_n;
   logic                 mosi;
   logic                 miso;
   logic                 miso_oe;
   logic                 busy;
   logic                 rx_valid;
   logic [WORD_SIZE-1:0] rx_data;
   logic                 tx_valid;
   logic [WORD_SIZE-1:0] tx_data;
   logic                 tx_ready;

   modport slave (
      input  sclk, cs_n, mosi, tx_valid, tx_data,
      output miso, miso_oe, busy, rx_valid, rx_data, tx_ready
   );

   modport master (
      output sclk, cs_n, mosi, tx_valid, tx_data,
      input  miso, miso_oe, busy, rx_valid, rx_data, tx_ready
   );
endinterface

// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave that deserializes MOSI into words for the Controller and
// serializes Controller result words onto MISO, with stretched rx/tx strobes.
module spi_word_bridge #(
   parameter int                   WORD_SIZE       = 16,
   parameter int                   RX_VALID_CYCLES = 4,
   parameter int                   TX_READY_CYCLES = 4,
   parameter logic [WORD_SIZE-1:0] TX_IDLE_WORD    = '0
) (
   input logic              clk_i,
   input logic              rst_i,
   spi_word_bridge_if.slave bus
);
   localparam int CNT_W = $clog2(WORD_SIZE);
   localparam int RXC_W = $clog2(RX_VALID_CYCLES + 1);
   localparam int TXC_W = $clog2(TX_READY_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);
   localparam logic [RXC_W-1:0] RX_LOAD  = RXC_W'(RX_VALID_CYCLES);
   localparam logic [TXC_W-1:0] TX_LOAD  = TXC_W'(TX_READY_CYCLES);

   typedef enum logic {IDLE, SHIFT} bridgeState_t;

   logic [1:0]           sclkSync_q, csnSync_q, mosiSync_q;
   logic                 sclkPrev_q, csnPrev_q;
   bridgeState_t         state_q;
   logic [CNT_W-1:0]     bitCnt_q;
   logic [WORD_SIZE-1:0] txShift_q;
   logic                 txOwned_q;
   logic [WORD_SIZE-2:0] rxShift_q;
   logic [WORD_SIZE-1:0] rxData_q;
   logic [RXC_W-1:0]     rxCnt_q;
   logic                 rxValid_q, rxRearm_q;
   logic [TXC_W-1:0]     txCnt_q;
   logic                 txReady_q, txRearm_q;

   logic sclkS, csnS, mosiS;
   logic sclkRise, sclkFall, csnRise, csnFall, wordDone, txDone;

   assign sclkS    = sclkSync_q[1];
   assign csnS     = csnSync_q[1];
   assign mosiS    = mosiSync_q[1];
   assign sclkRise = sclkS & ~sclkPrev_q;
   assign sclkFall = ~sclkS & sclkPrev_q;
   assign csnRise  = csnS & ~csnPrev_q;
   assign csnFall  = ~csnS & csnPrev_q;
   // A deselect in the same cycle as the last sclk rise cancels the word.
   assign wordDone = (state_q == SHIFT) & ~csnRise & sclkRise & (bitCnt_q == LAST_BIT);
   assign txDone   = wordDone & txOwned_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclkSync_q <= 2'b00;
         csnSync_q  <= 2'b11;
         mosiSync_q <= 2'b00;
         sclkPrev_q <= 1'b0;
         csnPrev_q  <= 1'b1;
      end else begin
         sclkSync_q <= {sclkSync_q[0], bus.sclk};
         csnSync_q  <= {csnSync_q[0], bus.cs_n};
         mosiSync_q <= {mosiSync_q[0], bus.mosi};
         sclkPrev_q <= sclkS;
         csnPrev_q  <= csnS;
      end
   end

   // A fall with bitCnt_q == 0 follows a completed word, so it reloads the next tx word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         bitCnt_q  <= '0;
         txShift_q <= '0;
         txOwned_q <= 1'b0;
         rxShift_q <= '0;
         rxData_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (csnFall) begin
                  state_q   <= SHIFT;
                  bitCnt_q  <= '0;
                  txShift_q <= bus.tx_valid ? bus.tx_data : TX_IDLE_WORD;
                  txOwned_q <= bus.tx_valid;
               end
            end
            SHIFT: begin
               if (csnRise) begin
                  state_q  <= IDLE;
                  bitCnt_q <= '0;
               end else if (sclkRise) begin
                  rxShift_q <= {rxShift_q[WORD_SIZE-3:0], mosiS};
                  if (bitCnt_q == LAST_BIT) begin
                     bitCnt_q <= '0;
                     rxData_q <= {rxShift_q, mosiS};
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end else if (sclkFall) begin
                  if (bitCnt_q != '0) begin
                     txShift_q <= {txShift_q[WORD_SIZE-2:0], 1'b0};
                  end else begin
                     txShift_q <= bus.tx_valid ? bus.tx_data : TX_IDLE_WORD;
                     txOwned_q <= bus.tx_valid;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A word landing mid-pulse drops rx_valid for one cycle so the Controller sees a new edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rxCnt_q   <= '0;
         rxValid_q <= 1'b0;
         rxRearm_q <= 1'b0;
      end else if (wordDone) begin
         if (rxCnt_q != '0) begin
            rxCnt_q   <= '0;
            rxValid_q <= 1'b0;
            rxRearm_q <= 1'b1;
         end else begin
            rxCnt_q   <= RX_LOAD;
            rxValid_q <= 1'b1;
            rxRearm_q <= 1'b0;
         end
      end else if (rxRearm_q) begin
         rxCnt_q   <= RX_LOAD;
         rxValid_q <= 1'b1;
         rxRearm_q <= 1'b0;
      end else if (rxCnt_q != '0) begin
         rxCnt_q   <= rxCnt_q - 1'b1;
         rxValid_q <= (rxCnt_q > RXC_W'(1));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         txCnt_q   <= '0;
         txReady_q <= 1'b0;
         txRearm_q <= 1'b0;
      end else if (txDone) begin
         if (txCnt_q != '0) begin
            txCnt_q   <= '0;
            txReady_q <= 1'b0;
            txRearm_q <= 1'b1;
         end else begin
            txCnt_q   <= TX_LOAD;
            txReady_q <= 1'b1;
            txRearm_q <= 1'b0;
         end
      end else if (txRearm_q) begin
         txCnt_q   <= TX_LOAD;
         txReady_q <= 1'b1;
         txRearm_q <= 1'b0;
      end else if (txCnt_q != '0) begin
         txCnt_q   <= txCnt_q - 1'b1;
         txReady_q <= (txCnt_q > TXC_W'(1));
      end
   end

   assign bus.miso     = ~csnS & txShift_q[WORD_SIZE-1];
   assign bus.miso_oe  = ~csnS;
   assign bus.busy     = (state_q == SHIFT);
   assign bus.rx_valid = rxValid_q;
   assign bus.rx_data  = rxData_q;
   assign bus.tx_ready = txReady_q;
endmodule

// File: tb/tb_spi_word_bridge.sv
// Self-checking bench for spi_word_bridge: an SPI master, a Controller model that
// offers tx words and pops them on tx_ready, and a pulse monitor feeding the checks.
module tb_spi_word_bridge;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] sendQ[$];
   logic [W-1:0] txOffer[$];
   logic [W-1:0] misoWords[$];
   logic [W-1:0] rxWords[$];
   int           rxLens[$];
   int           txLens[$];
   int           rxRun = 0;
   int           txRun = 0;
   logic         txReadyPrev = 1'b0;
   logic [W-1:0] modelRxData = '0;

   always #5 clk = ~clk;

   spi_word_bridge_if #(.WORD_SIZE(W)) bus();

   spi_word_bridge #(
      .WORD_SIZE(W),
      .RX_VALID_CYCLES(4),
      .TX_READY_CYCLES(4),
      .TX_IDLE_WORD(16'h0000)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus)
   );

   // Controller model and strobe monitor, sampled on the inactive clock edge.
   always @(negedge clk) begin
      if (bus.tx_ready && !txReadyPrev && txOffer.size() != 0) void'(txOffer.pop_front());
      txReadyPrev = bus.tx_ready;
      bus.tx_valid = (txOffer.size() != 0);
      bus.tx_data  = (txOffer.size() != 0) ? txOffer[0] : 16'h0000;
      if (bus.rx_valid) begin
         if (rxRun == 0) rxWords.push_back(bus.rx_data);
         rxRun++;
      end else if (rxRun != 0) begin
         rxLens.push_back(rxRun);
         rxRun = 0;
      end
      if (bus.tx_ready) txRun++;
      else if (txRun != 0) begin
         txLens.push_back(txRun);
         txRun = 0;
      end
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitClks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearMon();
      rxWords.delete();
      rxLens.delete();
      txLens.delete();
      misoWords.delete();
   endtask

   task automatic csLow();
      waitClks(2);
      bus.cs_n = 1'b0;
      waitClks(6);
   endtask

   task automatic csHigh();
      waitClks(4);
      bus.cs_n = 1'b1;
      waitClks(12);
   endtask

   task automatic spiBits(input int nBits);
      logic [W-1:0] cur;
      logic [W-1:0] misoAcc;
      misoAcc = '0;
      for (int i = 0; i < nBits; i++) begin
         cur = sendQ[i / W];
         bus.mosi = cur[W - 1 - (i % W)];
         waitClks(4);
         misoAcc = {misoAcc[W-2:0], bus.miso};
         if ((i % W) == W - 1) misoWords.push_back(misoAcc);
         bus.sclk = 1'b1;
         waitClks(4);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      waitClks(3);
      checks++; if (bus.miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", bus.miso); end
      checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", bus.miso_oe); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
      checks++; if (bus.rx_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 0000", bus.rx_data); end
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 0", bus.tx_ready); end
      rst = 1'b0;
      waitClks(4);
   endtask

   task automatic test_single_word();
      clearMon();
      sendQ = '{16'h3001};
      csLow();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
      checks++; if (bus.miso_oe !== 1'b1) begin errors++; $display("[TB] FAIL single_miso_oe: got %b expected 1", bus.miso_oe); end
      spiBits(W);
      csHigh();
      modelRxData = 16'h3001;
      checks++; if (rxLens.size() !== 1) begin errors++; $display("[TB] FAIL single_rx_pulses: got %0d expected 1", rxLens.size()); end
      checks++; if (rxLens[0] !== 4) begin errors++; $display("[TB] FAIL single_rx_len: got %0d expected 4", rxLens[0]); end
      checks++; if (rxWords[0] !== 16'h3001) begin errors++; $display("[TB] FAIL single_rx_word: got %h expected 3001", rxWords[0]); end
      checks++; if (bus.rx_data !== modelRxData) begin errors++; $display("[TB] FAIL single_rx_data_hold: got %h expected %h", bus.rx_data, modelRxData); end
      checks++; if (txLens.size() !== 0) begin errors++; $display("[TB] FAIL single_tx_pulses: got %0d expected 0", txLens.size()); end
      checks++; if (misoWords[0] !== 16'h0000) begin errors++; $display("[TB] FAIL single_miso_word: got %h expected 0000", misoWords[0]); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      clearMon();
      sendQ = '{16'h4000, 16'h00A5};
      csLow();
      spiBits(2 * W);
      csHigh();
      modelRxData = 16'h00A5;
      checks++; if (rxLens.size() !== 2) begin errors++; $display("[TB] FAIL b2b_rx_pulses: got %0d expected 2", rxLens.size()); end
      for (int i = 0; i < rxLens.size(); i++) begin
         checks++; if (rxLens[i] !== 4) begin errors++; $display("[TB] FAIL b2b_rx_len%0d: got %0d expected 4", i, rxLens[i]); end
      end
      checks++; if (rxWords[0] !== 16'h4000) begin errors++; $display("[TB] FAIL b2b_word0: got %h expected 4000", rxWords[0]); end
      checks++; if (rxWords[1] !== 16'h00A5) begin errors++; $display("[TB] FAIL b2b_word1: got %h expected 00a5", rxWords[1]); end
   endtask

   task automatic test_tx_path();
      logic [W-1:0] w0, w1;
      clearMon();
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      sendQ = '{w0, w1};
      txOffer = '{16'hA55A, 16'h0F0F};
      csLow();
      spiBits(2 * W);
      csHigh();
      modelRxData = w1;
      checks++; if (misoWords[0] !== 16'hA55A) begin errors++; $display("[TB] FAIL tx_miso0: got %h expected a55a", misoWords[0]); end
      checks++; if (misoWords[1] !== 16'h0F0F) begin errors++; $display("[TB] FAIL tx_miso1: got %h expected 0f0f", misoWords[1]); end
      checks++; if (txLens.size() !== 2) begin errors++; $display("[TB] FAIL tx_pulses: got %0d expected 2", txLens.size()); end
      for (int i = 0; i < txLens.size(); i++) begin
         checks++; if (txLens[i] !== 4) begin errors++; $display("[TB] FAIL tx_len%0d: got %0d expected 4", i, txLens[i]); end
      end
      checks++; if (txOffer.size() !== 0) begin errors++; $display("[TB] FAIL tx_consumed: got %0d expected 0", txOffer.size()); end
      checks++; if (rxWords[1] !== w1) begin errors++; $display("[TB] FAIL tx_rx_word1: got %h expected %h", rxWords[1], w1); end
   endtask

   task automatic test_abort();
      clearMon();
      sendQ = '{16'hFFFF};
      txOffer = '{16'hBEEF};
      csLow();
      spiBits(7);
      csHigh();
      checks++; if (rxLens.size() !== 0) begin errors++; $display("[TB] FAIL abort_rx_pulses: got %0d expected 0", rxLens.size()); end
      checks++; if (txLens.size() !== 0) begin errors++; $display("[TB] FAIL abort_tx_pulses: got %0d expected 0", txLens.size()); end
      checks++; if (bus.rx_data !== modelRxData) begin errors++; $display("[TB] FAIL abort_rx_data: got %h expected %h", bus.rx_data, modelRxData); end
      clearMon();
      sendQ = '{16'h1234};
      csLow();
      spiBits(W);
      csHigh();
      modelRxData = 16'h1234;
      checks++; if (rxLens.size() !== 1) begin errors++; $display("[TB] FAIL abort_next_rx_pulses: got %0d expected 1", rxLens.size()); end
      checks++; if (bus.rx_data !== 16'h1234) begin errors++; $display("[TB] FAIL abort_next_rx_data: got %h expected 1234", bus.rx_data); end
      checks++; if (txLens.size() !== 1) begin errors++; $display("[TB] FAIL abort_next_tx_pulses: got %0d expected 1", txLens.size()); end
      checks++; if (misoWords[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL abort_next_miso: got %h expected beef", misoWords[0]); end
      txOffer.delete();
   endtask

   task automatic test_reset_mid_frame();
      clearMon();
      sendQ = '{16'h5A5A};
      csLow();
      spiBits(9);
      rst = 1'b1;
      waitClks(2);
      checks++; if (bus.miso !== 1'b0) begin errors++; $display("[TB] FAIL midrst_miso: got %b expected 0", bus.miso); end
      checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL midrst_miso_oe: got %b expected 0", bus.miso_oe); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rx_valid: got %b expected 0", bus.rx_valid); end
      checks++; if (bus.rx_data !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_rx_data: got %h expected 0000", bus.rx_data); end
      checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tx_ready: got %b expected 0", bus.tx_ready); end
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      waitClks(2);
      rst = 1'b0;
      waitClks(4);
      clearMon();
      sendQ = '{16'h5002};
      csLow();
      spiBits(W);
      csHigh();
      modelRxData = 16'h5002;
      checks++; if (rxLens.size() !== 1) begin errors++; $display("[TB] FAIL midrst_rx_pulses: got %0d expected 1", rxLens.size()); end
      checks++; if (bus.rx_data !== 16'h5002) begin errors++; $display("[TB] FAIL midrst_rx_data_after: got %h expected 5002", bus.rx_data); end
   endtask

   task automatic test_idle_sclk();
      clearMon();
      bus.cs_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.mosi = 1'($urandom);
         bus.sclk = ~bus.sclk;
         waitClks(4);
         checks++; if (bus.miso !== 1'b0) begin errors++; $display("[TB] FAIL idle_miso%0d: got %b expected 0", i, bus.miso); end
         checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL idle_miso_oe%0d: got %b expected 0", i, bus.miso_oe); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy%0d: got %b expected 0", i, bus.busy); end
      end
      bus.sclk = 1'b0;
      waitClks(8);
      checks++; if (rxLens.size() !== 0) begin errors++; $display("[TB] FAIL idle_rx_pulses: got %0d expected 0", rxLens.size()); end
   endtask

   task automatic test_random();
      int           nWords, nOff, expTx;
      logic [W-1:0] offers[$];
      logic [W-1:0] expMiso;
      for (int f = 0; f < 8; f++) begin
         clearMon();
         nWords = $urandom_range(1, 3);
         nOff   = $urandom_range(0, 3);
         sendQ.delete();
         offers.delete();
         for (int i = 0; i < nWords; i++) sendQ.push_back(16'($urandom));
         for (int i = 0; i < nOff; i++) offers.push_back(16'($urandom));
         txOffer = offers;
         expTx = (nOff < nWords) ? nOff : nWords;
         csLow();
         spiBits(nWords * W);
         csHigh();
         txOffer.delete();
         modelRxData = sendQ[nWords - 1];
         checks++; if (rxLens.size() !== nWords) begin errors++; $display("[TB] FAIL rnd%0d_rx_pulses: got %0d expected %0d", f, rxLens.size(), nWords); end
         checks++; if (txLens.size() !== expTx) begin errors++; $display("[TB] FAIL rnd%0d_tx_pulses: got %0d expected %0d", f, txLens.size(), expTx); end
         checks++; if (bus.rx_data !== modelRxData) begin errors++; $display("[TB] FAIL rnd%0d_rx_data: got %h expected %h", f, bus.rx_data, modelRxData); end
         for (int i = 0; i < nWords; i++) begin
            expMiso = (i < nOff) ? offers[i] : 16'h0000;
            checks++; if (rxWords[i] !== sendQ[i]) begin errors++; $display("[TB] FAIL rnd%0d_rx_word%0d: got %h expected %h", f, i, rxWords[i], sendQ[i]); end
            checks++; if (misoWords[i] !== expMiso) begin errors++; $display("[TB] FAIL rnd%0d_miso%0d: got %h expected %h", f, i, misoWords[i], expMiso); end
         end
      end
   endtask

   initial begin
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_tx_path();
      test_abort();
      test_reset_mid_frame();
      test_idle_sclk();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
